// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format codes,
// base opcodes and the opcode-to-format decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_OPIMM32,
            OP_JALR, OP_SYSTEM, OP_FENCE:  return FMT_I;
            OP_STORE:                      return FMT_S;
            OP_BRANCH:                     return FMT_B;
            OP_LUI, OP_AUIPC:              return FMT_U;
            OP_JAL:                        return FMT_J;
            default:                       return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus between decode front end and execute/AGU stage.
// The master modport is the side that supplies instructions and consumes results.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int TAG_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    fmt_e             out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

endinterface

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extractor: (instr, fmt) -> sign-extended XLEN immediate.
// Stand-alone so other decoders can reuse it.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic signed [31:0] w_imm32;
    logic               w_unused_opcode;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends the 32-bit form to XLEN (no-op for RV32).
    assign o_imm = XLEN'(w_imm32);

    assign w_unused_opcode = ^i_instr[6:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready RISC-V immediate generator (decode, then extract).
// Define IMM_GEN_PERF_EN to add saturating perf_total/perf_illegal counters.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_gen_pipe_if.slave    bus
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_total,
    output logic [CNT_W-1:0] perf_illegal
`endif
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (ILEN != 32) begin : g_bad_ilen
        $error("imm_gen_pipe: ILEN must be 32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("imm_gen_pipe: CNT_W must be at least 1");
    end

    logic             w_s1_en;
    logic             w_s2_en;
    logic [XLEN-1:0]  w_imm;

    logic             r_s1_valid;
    logic [ILEN-1:0]  r_s1_instr;
    logic [TAG_W-1:0] r_s1_tag;
    fmt_e             r_s1_fmt;

    logic             r_s2_valid;
    logic [XLEN-1:0]  r_out_imm;
    fmt_e             r_out_fmt;
    logic             r_out_illegal;
    logic [TAG_W-1:0] r_out_tag;

    // A stage may load when it is empty or its contents leave this cycle.
    assign w_s2_en     = !r_s2_valid || bus.out_ready;
    assign w_s1_en     = !r_s1_valid || w_s2_en;
    assign bus.in_ready = w_s1_en;

    // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
    // NOTE: data registers are reset too, because the output bus has defined reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_tag   <= '0;
            r_s1_fmt   <= FMT_NONE;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_instr <= bus.in_instr;
                r_s1_tag   <= bus.in_tag;
                r_s1_fmt   <= decode_fmt(bus.in_instr[6:0]);
            end
        end
    end

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr (r_s1_instr),
        .i_fmt   (r_s1_fmt),
        .o_imm   (w_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid    <= 1'b0;
            r_out_imm     <= '0;
            r_out_fmt     <= FMT_NONE;
            r_out_illegal <= 1'b0;
            r_out_tag     <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_imm     <= w_imm;
                r_out_fmt     <= r_s1_fmt;
                r_out_illegal <= (r_s1_fmt == FMT_NONE);
                r_out_tag     <= r_s1_tag;
            end
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.out_imm     = r_out_imm;
    assign bus.out_fmt     = r_out_fmt;
    assign bus.out_illegal = r_out_illegal;
    assign bus.out_tag     = r_out_tag;

`ifdef IMM_GEN_PERF_EN
    logic             w_out_fire;
    logic [CNT_W-1:0] r_perf_total;
    logic [CNT_W-1:0] r_perf_illegal;

    assign w_out_fire = r_s2_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_total   <= '0;
            r_perf_illegal <= '0;
        end else if (w_out_fire) begin
            if (r_perf_total != '1) begin
                r_perf_total <= r_perf_total + CNT_W'(1);
            end
            if (r_out_illegal && r_perf_illegal != '1) begin
                r_perf_illegal <= r_perf_illegal + CNT_W'(1);
            end
        end
    end

    assign perf_total   = r_perf_total;
    assign perf_illegal = r_perf_illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure, reset flush
// and randomized traffic against an arithmetic reference model and scoreboard.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .ILEN(32), .TAG_W(8)) bus ();

`ifdef IMM_GEN_PERF_EN
    logic [15:0] perf_total;
    logic [15:0] perf_illegal;
`endif

    imm_gen_pipe #(.XLEN(64), .ILEN(32), .TAG_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef IMM_GEN_PERF_EN
        ,
        .perf_total   (perf_total),
        .perf_illegal (perf_illegal)
`endif
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference: format table and immediates built with plain signed arithmetic.
    function automatic logic [2:0] ref_fmt(input logic [31:0] instr);
        case (instr[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F: return 3'd1;
            7'h23:                                    return 3'd2;
            7'h63:                                    return 3'd3;
            7'h37, 7'h17:                             return 3'd4;
            7'h6F:                                    return 3'd5;
            default:                                  return 3'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] instr);
        longint s;
        longint v;
        s = longint'($signed(instr));
        case (ref_fmt(instr))
            3'd1: v = s >>> 20;
            3'd2: v = (s >>> 25) * 32 + longint'(instr[11:7]);
            3'd3: v = (instr[31] ? -4096 : 0) + longint'(instr[7]) * 2048
                      + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
            3'd4: v = s & ~longint'(4095);
            3'd5: v = (instr[31] ? -1048576 : 0) + longint'(instr[19:12]) * 4096
                      + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [7:0] tag);
        exp_t e;
        e.fmt = ref_fmt(instr);
        e.imm = ref_imm(instr);
        e.ill = (e.fmt == 3'd0);
        e.tag = tag;
        return e;
    endfunction

    function automatic exp_t obs();
        return {bus.out_imm, 3'(bus.out_fmt), bus.out_illegal, bus.out_tag};
    endfunction

    function automatic logic [31:0] rand_instr(input bit legal);
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom();
        if (legal) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [7:0] tag,
                          input logic rdy);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, '0, 1'b1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        set_in(1'b0, '0, '0, 1'b1);
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (obs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", obs());
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
`ifdef IMM_GEN_PERF_EN
        total++;
        if ({perf_total, perf_illegal} !== '0) begin
            bad++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_total, perf_illegal);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Test-plan vectors, one at a time, checking the 2-cycle latency exactly.
    task automatic test_directed();
        logic [31:0] ins [5];
        logic [63:0] imm [5];
        logic [2:0]  fmt [5];
        exp_t        e;
        ins = '{32'hFF813083, 32'h00513823, 32'hFE000EE3, 32'h800000B7, 32'h0010006F};
        imm = '{64'hFFFFFFFFFFFFFFF8, 64'h10, 64'hFFFFFFFFFFFFFFFC,
                64'hFFFFFFFF80000000, 64'h800};
        fmt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, ins[i], 8'(16 + i), 1'b1);
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            tick();
            set_in(1'b0, '0, '0, 1'b1);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL dir_latency1[%0d]: out_valid got %b want 0", i, bus.out_valid);
            end
            tick();
            e = '{imm: imm[i], fmt: fmt[i], ill: 1'b0, tag: 8'(16 + i)};
            total++;
            if (bus.out_valid !== 1'b1 || obs() !== e) begin
                bad++; $display("FAIL dir_result[%0d]: got v=%b %h want v=1 %h",
                                i, bus.out_valid, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        do_reset();
        set_in(1'b1, 32'h0000007F, 8'h5A, 1'b1);
        tick();
        set_in(1'b0, '0, '0, 1'b1);
        tick();
        e = '{imm: 64'h0, fmt: 3'd0, ill: 1'b1, tag: 8'h5A};
        total++;
        if (bus.out_valid !== 1'b1 || obs() !== e) begin
            bad++; $display("FAIL illegal_result: got v=%b %h want v=1 %h", bus.out_valid, obs(), e);
        end
        tick();
`ifdef IMM_GEN_PERF_EN
        total++;
        if (perf_total !== 16'd1 || perf_illegal !== 16'd1) begin
            bad++; $display("FAIL illegal_perf: got %0d/%0d want 1/1", perf_total, perf_illegal);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3];
        exp_t        e;
        do_reset();
        for (int i = 0; i < 3; i++) ins[i] = rand_instr(1'b1);
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, ins[i], 8'(i + 1), 1'b0);
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL bp_accept[%0d]: in_ready got %b want 1", i, bus.in_ready);
            end
            tick();
        end
        set_in(1'b1, ins[2], 8'd3, 1'b0);
        e = model(ins[0], 8'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_full[%0d]: in_ready got %b want 0", k, bus.in_ready);
            end
            total++;
            if (bus.out_valid !== 1'b1 || obs() !== e) begin
                bad++; $display("FAIL bp_stable[%0d]: got v=%b %h want v=1 %h",
                                k, bus.out_valid, obs(), e);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
                end
            end
            e = model(ins[i], 8'(i + 1));
            total++;
            if (bus.out_valid !== 1'b1 || obs() !== e) begin
                bad++; $display("FAIL bp_drain[%0d]: got v=%b %h want v=1 %h",
                                i, bus.out_valid, obs(), e);
            end
            tick();
            set_in(1'b0, '0, '0, 1'b1);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_flush();
        logic [31:0] ins;
        do_reset();
        set_in(1'b1, rand_instr(1'b1), 8'hA1, 1'b0);
        tick();
        set_in(1'b1, rand_instr(1'b1), 8'hA2, 1'b0);
        tick();
        set_in(1'b0, '0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || obs() !== '0) begin
            bad++; $display("FAIL flush_async: got v=%b %h want v=0 0", bus.out_valid, obs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ins = rand_instr(1'b1);
        set_in(1'b1, ins, 8'hC3, 1'b1);
        tick();
        set_in(1'b0, '0, '0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_stale: out_valid got %b want 0", bus.out_valid);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || obs() !== model(ins, 8'hC3)) begin
            bad++; $display("FAIL flush_new: got v=%b %h want v=1 %h",
                            bus.out_valid, obs(), model(ins, 8'hC3));
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_after: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    // Random traffic: scoreboard order, occupancy-based ready, and stall stability.
    task automatic test_random();
        logic        v, rdy, prev_stall;
        logic [31:0] ins;
        logic [7:0]  tag;
        exp_t        snap, e;
        int          n_tot, n_ill;
        sb.delete();
        do_reset();
        prev_stall = 1'b0;
        snap       = '0;
        n_tot      = 0;
        n_ill      = 0;
        for (int c = 0; c < 2000; c++) begin
            v   = ($urandom() % 4) != 0;
            rdy = ($urandom() % 3) != 0;
            ins = rand_instr(($urandom() % 8) != 0);
            tag = 8'($urandom());
            set_in(v, ins, tag, rdy);
            @(negedge clk);
            total++;
            if (bus.in_ready !== !(sb.size() == 2 && !rdy)) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b (inflight=%0d)",
                                c, bus.in_ready, !(sb.size() == 2 && !rdy), sb.size());
            end
            if (prev_stall) begin
                total++;
                if (bus.out_valid !== 1'b1 || obs() !== snap) begin
                    bad++; $display("FAIL rnd_stall[%0d]: got v=%b %h want v=1 %h",
                                    c, bus.out_valid, obs(), snap);
                end
            end
            if (bus.out_valid === 1'b1 && rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rnd_extra[%0d]: got %h want nothing", c, obs());
                end else begin
                    e = sb.pop_front();
                    n_tot++;
                    if (e.ill) n_ill++;
                    if (obs() !== e) begin
                        bad++; $display("FAIL rnd_data[%0d]: got %h want %h", c, obs(), e);
                    end
                end
            end
            if (v && bus.in_ready === 1'b1) sb.push_back(model(ins, tag));
            prev_stall = (bus.out_valid === 1'b1) && !rdy;
            snap       = obs();
            tick();
        end
        set_in(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                e = sb.pop_front();
                n_tot++;
                if (e.ill) n_ill++;
                total++;
                if (obs() !== e) begin
                    bad++; $display("FAIL rnd_drain: got %h want %h", obs(), e);
                end
            end
            tick();
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL rnd_timeout: %0d results outstanding, want 0", sb.size());
        end
`ifdef IMM_GEN_PERF_EN
        total++;
        if (perf_total !== 16'(n_tot) || perf_illegal !== 16'(n_ill)) begin
            bad++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d",
                            perf_total, perf_illegal, n_tot, n_ill);
        end
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, 1'b1);
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_reset_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
